// File: rtl/mem_arb_pkg.sv
// -----------------------------------------------------------------------------
// mem_arb_pkg
// Shared types and constants for the unified-memory arbiter.
//   arb_state_t : arbiter FSM states
//   TIMEOUT_W   : width of the response-timeout counter
// -----------------------------------------------------------------------------
package mem_arb_pkg;

    localparam int TIMEOUT_W = 8;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        I_ISSUE = 3'd1,
        I_WAIT  = 3'd2,
        D_ISSUE = 3'd3,
        D_WAIT  = 3'd4
    } arb_state_t;

endpackage

// File: rtl/mem_timeout_cnt.sv
// -----------------------------------------------------------------------------
// mem_timeout_cnt
// Cycle counter bounding how long one memory transaction may stay in flight.
// Ports:
//   clk, rst   : clock, asynchronous active-low reset
//   i_clr      : synchronous clear (held while the arbiter is idle)
//   i_en       : count this cycle (transaction in flight)
//   o_expired  : in-flight cycle whose count has reached TIMEOUT
// -----------------------------------------------------------------------------
module mem_timeout_cnt
    import mem_arb_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expired
);

    logic [TIMEOUT_W-1:0] r_cnt;

    // Saturates at all-ones so a stuck enable can never wrap back below TIMEOUT.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en && (r_cnt != '1)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_expired = i_en && (r_cnt == TIMEOUT_W'(TIMEOUT));

endmodule

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
// Serialises the instruction-fetch and data-access channels onto a single
// req/rdy/valid memory port. Data has fixed priority over instruction fetch.
// Each grant yields exactly one registered *_valid pulse, flagged with *_err
// (and zero rdata) when the memory fails to respond within TIMEOUT cycles.
// Ports:
//   clk, rst                     : clock, asynchronous active-low reset
//   i_req/i_addr                 : fetch request (held until i_valid)
//   i_rdata/i_valid/i_err        : fetch response
//   i_stall                      : i_req & ~i_valid
//   d_req/d_wen/d_addr/d_wdata   : data request (held until d_valid)
//   d_rdata/d_valid/d_err        : data response / write ack
//   d_stall                      : d_req & ~d_valid
//   mem_req/mem_addr/mem_wdata/mem_wen : request to memory (registered)
//   mem_rdy                      : memory accepts when mem_req & mem_rdy
//   mem_valid/mem_rdata          : memory response
// -----------------------------------------------------------------------------
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NBITS   = 32,
    parameter int TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_req,
    input  logic [NBITS-1:0] i_addr,
    output logic [NBITS-1:0] i_rdata,
    output logic             i_valid,
    output logic             i_err,
    output logic             i_stall,
    input  logic             d_req,
    input  logic             d_wen,
    input  logic [NBITS-1:0] d_addr,
    input  logic [NBITS-1:0] d_wdata,
    output logic [NBITS-1:0] d_rdata,
    output logic             d_valid,
    output logic             d_err,
    output logic             d_stall,
    output logic             mem_req,
    output logic [NBITS-1:0] mem_addr,
    output logic [NBITS-1:0] mem_wdata,
    output logic             mem_wen,
    input  logic             mem_rdy,
    input  logic             mem_valid,
    input  logic [NBITS-1:0] mem_rdata
);

    arb_state_t       r_state;
    logic             r_mem_req;
    logic [NBITS-1:0] r_addr;
    logic [NBITS-1:0] r_wdata;
    logic             r_wen;
    logic [NBITS-1:0] r_i_rdata;
    logic             r_i_valid;
    logic             r_i_err;
    logic [NBITS-1:0] r_d_rdata;
    logic             r_d_valid;
    logic             r_d_err;

    logic w_d_elig, w_i_elig;
    logic w_issue, w_wait, w_is_d;
    logic w_expired, w_complete, w_done, w_err;

    // A request whose response is being pulsed this cycle is being retired,
    // so it must not be granted again.
    assign w_d_elig   = d_req & ~r_d_valid;
    assign w_i_elig   = i_req & ~r_i_valid;

    assign w_issue    = (r_state == I_ISSUE) || (r_state == D_ISSUE);
    assign w_wait     = (r_state == I_WAIT)  || (r_state == D_WAIT);
    assign w_is_d     = (r_state == D_ISSUE) || (r_state == D_WAIT);

    // mem_valid only counts in a wait state; a real completion beats a
    // timeout landing in the same cycle.
    assign w_complete = w_wait & mem_valid;
    assign w_done     = w_complete | w_expired;
    assign w_err      = w_expired & ~w_complete;

    mem_timeout_cnt #(
        .TIMEOUT   (TIMEOUT)
    ) u_tmo (
        .clk       (clk),
        .rst       (rst),
        .i_clr     (r_state == IDLE),
        .i_en      (w_issue | w_wait),
        .o_expired (w_expired)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= IDLE;
            r_mem_req <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_wen     <= 1'b0;
            r_i_rdata <= '0;
            r_i_valid <= 1'b0;
            r_i_err   <= 1'b0;
            r_d_rdata <= '0;
            r_d_valid <= 1'b0;
            r_d_err   <= 1'b0;
        end else begin
            r_i_valid <= 1'b0;
            r_i_err   <= 1'b0;
            r_d_valid <= 1'b0;
            r_d_err   <= 1'b0;

            case (r_state)
                IDLE: begin
                    if (w_d_elig) begin
                        r_state   <= D_ISSUE;
                        r_mem_req <= 1'b1;
                        r_addr    <= d_addr;
                        r_wen     <= d_wen;
                        r_wdata   <= d_wdata;
                    end else if (w_i_elig) begin
                        r_state   <= I_ISSUE;
                        r_mem_req <= 1'b1;
                        r_addr    <= i_addr;
                        r_wen     <= 1'b0;
                        r_wdata   <= '0;
                    end
                end
                I_ISSUE, D_ISSUE: begin
                    if (w_done) begin
                        r_state   <= IDLE;
                        r_mem_req <= 1'b0;
                    end else if (mem_rdy) begin
                        r_state   <= (r_state == D_ISSUE) ? D_WAIT : I_WAIT;
                        r_mem_req <= 1'b0;
                    end
                end
                I_WAIT, D_WAIT: begin
                    if (w_done) begin
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state   <= IDLE;
                    r_mem_req <= 1'b0;
                end
            endcase

            if (w_done) begin
                if (w_is_d) begin
                    r_d_valid <= 1'b1;
                    r_d_err   <= w_err;
                    r_d_rdata <= w_err ? '0 : mem_rdata;
                end else begin
                    r_i_valid <= 1'b1;
                    r_i_err   <= w_err;
                    r_i_rdata <= w_err ? '0 : mem_rdata;
                end
            end
        end
    end

    assign mem_req   = r_mem_req;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;
    assign mem_wen   = r_wen;
    assign i_rdata   = r_i_rdata;
    assign i_valid   = r_i_valid;
    assign i_err     = r_i_err;
    assign d_rdata   = r_d_rdata;
    assign d_valid   = r_d_valid;
    assign d_err     = r_d_err;
    assign i_stall   = i_req & ~r_i_valid;
    assign d_stall   = d_req & ~r_d_valid;

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
// Random and directed stimulus against a transaction-level reference: at each
// grant the bench picks the memory's rdy/valid delays, so the response cycle,
// error flag and data of every transaction follow from plain arithmetic.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

    localparam int NB = 32;
    localparam int TO = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          i_req = 1'b0;
    logic [NB-1:0] i_addr = '0;
    logic          d_req = 1'b0;
    logic          d_wen = 1'b0;
    logic [NB-1:0] d_addr = '0;
    logic [NB-1:0] d_wdata = '0;
    logic          mem_rdy = 1'b0;
    logic          mem_valid = 1'b0;
    logic [NB-1:0] mem_rdata = '0;
    logic [NB-1:0] i_rdata, d_rdata, mem_addr, mem_wdata;
    logic          i_valid, i_err, i_stall, d_valid, d_err, d_stall;
    logic          mem_req, mem_wen;

    mem_arbiter #(.NBITS(NB), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_valid(i_valid),
        .i_err(i_err), .i_stall(i_stall),
        .d_req(d_req), .d_wen(d_wen), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_valid(d_valid), .d_err(d_err), .d_stall(d_stall),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wen(mem_wen), .mem_rdy(mem_rdy), .mem_valid(mem_valid),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    typedef struct { logic [NB-1:0] addr; logic wen; logic [NB-1:0] wdata; } req_t;
    typedef struct { int rdy; int val; logic [NB-1:0] rdata; } dly_t;

    req_t iq[$];
    req_t dq[$];
    dly_t mq[$];

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    // reference state: one transaction at a time
    bit            has_tx = 0, t_d = 0, t_wen = 0, t_err = 0;
    int            g = 0, t_rdy = 0, t_c = 0, resp_cyc = 0;
    logic [NB-1:0] t_rdata = '0;
    logic [NB-1:0] h_addr = '0, h_wdata = '0;
    logic          h_wen = 1'b0;
    logic [NB-1:0] i_rd_exp = '0, d_rd_exp = '0;
    bit            d_rd_known = 1;
    bit            i_owed = 0, d_owed = 0, rand_en = 0, force_mv = 0;

    task automatic chk(input string tag, input logic [NB-1:0] got, input logic [NB-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic step();
        int   k;
        bit   active, issue;
        bit   ev_i, ee_i, ev_d, ee_d;
        bit   gd, gi;
        int   val;
        req_t r;
        dly_t m;
        @(posedge clk);
        #1;
        cyc++;
        ev_i = 0; ee_i = 0; ev_d = 0; ee_d = 0;
        if (has_tx && cyc == resp_cyc) begin
            if (t_d) begin
                ev_d = 1; ee_d = t_err;
                if (t_err || !t_wen) begin
                    d_rd_exp   = t_err ? '0 : t_rdata;
                    d_rd_known = 1;
                end else begin
                    d_rd_known = 0;
                end
            end else begin
                ev_i = 1; ee_i = t_err;
                i_rd_exp = t_err ? '0 : t_rdata;
            end
        end
        active = has_tx && (cyc > g) && (cyc < resp_cyc);
        k      = cyc - g - 1;
        issue  = active && (k <= ((t_rdy < TO) ? t_rdy : TO));

        chk("i_valid",   32'(i_valid),   32'(ev_i));
        chk("i_err",     32'(i_err),     32'(ee_i));
        chk("d_valid",   32'(d_valid),   32'(ev_d));
        chk("d_err",     32'(d_err),     32'(ee_d));
        chk("mem_req",   32'(mem_req),   32'(issue));
        chk("mem_addr",  mem_addr,       h_addr);
        chk("mem_wen",   32'(mem_wen),   32'(h_wen));
        chk("mem_wdata", mem_wdata,      h_wdata);
        chk("i_rdata",   i_rdata,        i_rd_exp);
        if (d_rd_known) chk("d_rdata", d_rdata, d_rd_exp);

        // requestors
        if (ev_i) i_owed = 0;
        if (ev_d) d_owed = 0;
        if (!i_owed) begin
            i_req = 1'b0;
            if (iq.size() > 0) begin
                r = iq.pop_front();
                i_addr = r.addr; i_req = 1'b1; i_owed = 1;
            end else if (rand_en && ($urandom % 3 == 0)) begin
                i_addr = $urandom; i_req = 1'b1; i_owed = 1;
            end
        end else if (rand_en && active && !t_d && ($urandom % 8 == 0)) begin
            i_req = 1'b0;
        end
        if (!d_owed) begin
            d_req = 1'b0;
            if (dq.size() > 0) begin
                r = dq.pop_front();
                d_addr = r.addr; d_wen = r.wen; d_wdata = r.wdata; d_req = 1'b1; d_owed = 1;
            end else if (rand_en && ($urandom % 3 == 0)) begin
                d_addr = $urandom; d_wen = 1'($urandom_range(0, 1)); d_wdata = $urandom;
                d_req = 1'b1; d_owed = 1;
            end
        end else if (rand_en && active && t_d && ($urandom % 8 == 0)) begin
            d_req = 1'b0;
        end

        // memory: scheduled handshakes, random noise where the arbiter must ignore it
        mem_rdy   = 1'($urandom_range(0, 1));
        mem_valid = ($urandom % 4 == 0) || force_mv;
        mem_rdata = $urandom;
        if (active) begin
            if (issue) begin
                mem_rdy = (k == t_rdy);
            end else begin
                mem_valid = (k == t_c);
                if (k == t_c) mem_rdata = t_rdata;
            end
        end

        #1;
        chk("i_stall", 32'(i_stall), 32'(i_req & ~ev_i));
        chk("d_stall", 32'(d_stall), 32'(d_req & ~ev_d));

        // grant decision at the end of an idle cycle
        if (!(has_tx && cyc < resp_cyc)) begin
            gd = d_req && !ev_d;
            gi = i_req && !ev_i;
            if (gd || gi) begin
                has_tx  = 1;
                t_d     = gd;
                g       = cyc;
                t_wen   = gd ? d_wen : 1'b0;
                h_addr  = gd ? d_addr : i_addr;
                h_wen   = t_wen;
                h_wdata = gd ? d_wdata : '0;
                if (mq.size() > 0) begin
                    m = mq.pop_front();
                    t_rdy = m.rdy; val = m.val; t_rdata = m.rdata;
                end else begin
                    t_rdy   = ($urandom % 4 == 0) ? int'($urandom_range(0, 5)) : int'($urandom_range(0, 1));
                    val     = ($urandom % 4 == 0) ? int'($urandom_range(0, 5)) : int'($urandom_range(0, 1));
                    t_rdata = $urandom;
                end
                t_c = t_rdy + 1 + val;
                if (t_c <= TO) begin
                    t_err = 0; resp_cyc = g + 2 + t_c;
                end else begin
                    t_err = 1; resp_cyc = g + 2 + TO;
                end
            end
        end
    endtask

    task automatic model_reset();
        has_tx = 0; h_addr = '0; h_wdata = '0; h_wen = 1'b0;
        i_rd_exp = '0; d_rd_exp = '0; d_rd_known = 1;
        i_owed = 0; d_owed = 0;
        iq.delete(); dq.delete(); mq.delete();
    endtask

    initial begin
        bit reached;
        rst = 1'b0;
        #2;
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_i_valid", 32'(i_valid), 32'd0);
        chk("rst_d_valid", 32'(d_valid), 32'd0);
        chk("rst_mem_addr", mem_addr, '0);
        repeat (2) @(negedge clk);
        rst = 1'b1;

        // single read
        iq.push_back('{addr: 32'h100, wen: 1'b0, wdata: '0});
        mq.push_back('{rdy: 0, val: 0, rdata: 32'h0050_0093});
        repeat (10) step();

        // contention: data read first, then fetch
        iq.push_back('{addr: 32'h104, wen: 1'b0, wdata: '0});
        dq.push_back('{addr: 32'h2000, wen: 1'b0, wdata: '0});
        mq.push_back('{rdy: 0, val: 0, rdata: 32'hAAAA_0001});
        mq.push_back('{rdy: 0, val: 0, rdata: 32'h5555_0002});
        repeat (14) step();

        // write with mem_rdy delayed by two cycles
        dq.push_back('{addr: 32'h2004, wen: 1'b1, wdata: 32'hDEAD_BEEF});
        mq.push_back('{rdy: 2, val: 0, rdata: 32'h1234_5678});
        repeat (12) step();

        // timeout: accepted but never answered
        dq.push_back('{addr: 32'h3000, wen: 1'b0, wdata: '0});
        mq.push_back('{rdy: 0, val: 9, rdata: 32'hFFFF_FFFF});
        repeat (12) step();

        // random traffic
        rand_en = 1;
        repeat (3000) step();

        // drain, then reset in the middle of a fetch's wait phase
        rand_en = 0;
        repeat (20) step();
        iq.push_back('{addr: 32'h400, wen: 1'b0, wdata: '0});
        mq.push_back('{rdy: 0, val: 3, rdata: 32'hCAFE_F00D});
        reached = 0;
        for (int n = 0; n < 20 && !reached; n++) begin
            step();
            if (has_tx && !t_d && cyc == g + 2) reached = 1;
        end
        chk("rst_reach_wait", 32'(reached), 32'd1);
        #1;
        rst = 1'b0; i_req = 1'b0; d_req = 1'b0; mem_valid = 1'b0; mem_rdy = 1'b0;
        #1;
        chk("arst_mem_req",   32'(mem_req),   32'd0);
        chk("arst_mem_addr",  mem_addr,       '0);
        chk("arst_mem_wen",   32'(mem_wen),   32'd0);
        chk("arst_mem_wdata", mem_wdata,      '0);
        chk("arst_i_valid",   32'(i_valid),   32'd0);
        chk("arst_i_err",     32'(i_err),     32'd0);
        chk("arst_d_valid",   32'(d_valid),   32'd0);
        chk("arst_d_err",     32'(d_err),     32'd0);
        chk("arst_i_rdata",   i_rdata,        '0);
        chk("arst_d_rdata",   d_rdata,        '0);
        chk("arst_i_stall",   32'(i_stall),   32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        force_mv = 1;
        repeat (6) step();
        force_mv = 0;

        rand_en = 1;
        repeat (200) step();
        rand_en = 0;
        repeat (20) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
